// File: rtl/cla_pkg.sv
// Shared KPG encoding and elaboration helpers for the pipelined CLA.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package cla_pkg;

    typedef logic [1:0] kpg_t;

    localparam kpg_t KPG_K = 2'b00;
    localparam kpg_t KPG_P = 2'b01;
    localparam kpg_t KPG_G = 2'b11;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return r;
    endfunction

    // Register cuts sit at the centres of equal slices of the step sequence
    // (KPG generation, then each prefix level); result is 1 if a cut follows 'step'.
    function automatic bit cut_after(input int step, input int cuts, input int levels);
        bit hit;
        hit = 1'b0;
        for (int j = 1; j <= cuts; j++) begin
            if (((2 * j - 1) * (levels + 1)) / (2 * cuts) == step) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

endpackage

// File: rtl/kpg_combine.sv
// Two-input KPG prefix operator: the higher group wins unless it only propagates.
// Latency: combinational.
// Backpressure: n/a.
module kpg_combine
    import cla_pkg::*;
(
    input  kpg_t hi,
    input  kpg_t lo,
    output kpg_t out
);

    assign out = (hi != KPG_P) ? hi : lo;

endmodule

// File: rtl/cla_pipe_addsub.sv
// Pipelined carry-lookahead adder/subtractor built on a Kogge-Stone KPG prefix tree.
// Latency: PIPE_STAGES cycles from accepted beat to out_valid; one beat per cycle.
// Backpressure: global stall, in_ready = out_ready | ~out_valid; every stage holds together.
module cla_pipe_addsub
    import cla_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int PIPE_STAGES = 2,
    parameter int TAG_W       = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic [TAG_W-1:0] out_tag
);

    localparam int LEVELS = clog2(WIDTH);
    localparam int CUTS   = PIPE_STAGES - 1;

    // Sideband that rides alongside the KPG vector through the tree.
    typedef struct packed {
        logic             vld;
        logic [TAG_W-1:0] tag;
        logic [WIDTH-1:0] hs;
        logic             c0;
    } meta_t;

    logic             advance;
    logic [WIDTH-1:0] b_eff;
    meta_t            in_meta;
    kpg_t [WIDTH-1:0] gen_kpg;

    assign advance  = out_ready | ~out_valid;
    assign in_ready = advance;
    assign b_eff    = sub ? ~b : b;

    always_comb begin
        in_meta     = '0;
        in_meta.vld = in_valid & advance;
        in_meta.tag = in_tag;
        in_meta.hs  = a ^ b_eff;
        in_meta.c0  = sub | cin;
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_kpg
        kpg_t raw;
        assign raw = (a[i] & b_eff[i]) ? KPG_G : ((a[i] ^ b_eff[i]) ? KPG_P : KPG_K);
        if (i == 0) begin : g_seed
            // Folding carry-in into bit 0 keeps every group term G or K after the tree.
            kpg_combine u_seed (
                .hi  (raw),
                .lo  (in_meta.c0 ? KPG_G : KPG_K),
                .out (gen_kpg[0])
            );
        end else begin : g_bit
            assign gen_kpg[i] = raw;
        end
    end

    // Step 0 is KPG generation; step s>0 is prefix level s with span 2**(s-1).
    for (genvar s = 0; s <= LEVELS; s++) begin : g_st
        kpg_t [WIDTH-1:0] comb;
        kpg_t [WIDTH-1:0] q;
        meta_t            m_in;
        meta_t            mq;

        if (s == 0) begin : g_gen
            assign comb = gen_kpg;
            assign m_in = in_meta;
        end else begin : g_tree
            localparam int D = 1 << (s - 1);
            assign m_in = g_st[s-1].mq;
            for (genvar i = 0; i < WIDTH; i++) begin : g_bit
                if (i >= D) begin : g_node
                    kpg_combine u_node (
                        .hi  (g_st[s-1].q[i]),
                        .lo  (g_st[s-1].q[i-D]),
                        .out (comb[i])
                    );
                end else begin : g_pass
                    assign comb[i] = g_st[s-1].q[i];
                end
            end
        end

        if (cut_after(s, CUTS, LEVELS)) begin : g_cut
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    q  <= '0;
                    mq <= '0;
                end else if (advance) begin
                    q  <= comb;
                    mq <= m_in;
                end
            end
        end else begin : g_thru
            assign q  = comb;
            assign mq = m_in;
        end
    end

    kpg_t [WIDTH-1:0] grp;
    meta_t            fin;
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum_nxt;

    assign grp = g_st[LEVELS].q;
    assign fin = g_st[LEVELS].mq;

    always_comb begin
        carry    = '0;
        carry[0] = fin.c0;
        for (int i = 0; i < WIDTH; i++) begin
            carry[i+1] = (grp[i] == KPG_G);
        end
    end

    assign sum_nxt = fin.hs ^ carry[WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            zero      <= 1'b0;
            out_tag   <= '0;
        end else if (advance) begin
            out_valid <= fin.vld;
            sum       <= sum_nxt;
            cout      <= carry[WIDTH];
            ovf       <= carry[WIDTH] ^ carry[WIDTH-1];
            zero      <= (sum_nxt == '0);
            out_tag   <= fin.tag;
        end
    end

endmodule

// File: tb/tb_cla_pipe_addsub.sv
// Bench for cla_pipe_addsub: directed vector table, stall/reset sequences, random stream,
// all results checked in order against a queue of expected outputs.
module tb_cla_pipe_addsub;

    localparam int W  = 16;
    localparam int PS = 2;
    localparam int TW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          cin;
    logic          sub;
    logic [TW-1:0] in_tag;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  sum;
    logic          cout;
    logic          ovf;
    logic          zero;
    logic [TW-1:0] out_tag;

    always #5 clk = ~clk;

    cla_pipe_addsub #(
        .WIDTH       (W),
        .PIPE_STAGES (PS),
        .TAG_W       (TW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .zero      (zero),
        .out_tag   (out_tag)
    );

    typedef struct packed {
        logic [W-1:0]  sum;
        logic          cout;
        logic          ovf;
        logic          zero;
        logic [TW-1:0] tag;
    } exp_t;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         sub;
        logic [W-1:0] e_sum;
        logic         e_cout;
        logic         e_ovf;
        logic         e_zero;
    } vec_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_acc   = 0;
    int   n_out   = 0;
    bit   mon_en  = 1'b0;
    bit   rnd_done;
    vec_t vt[11];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic c, input logic s, input logic [TW-1:0] t);
        logic [W-1:0] yy;
        logic [W:0]   full;
        exp_t         e;
        yy     = s ? ~y : y;
        full   = {1'b0, x} + {1'b0, yy} + {{W{1'b0}}, (s ? 1'b1 : c)};
        e.sum  = full[W-1:0];
        e.cout = full[W];
        e.ovf  = (x[W-1] == yy[W-1]) && (full[W-1] != x[W-1]);
        e.zero = (full[W-1:0] == '0);
        e.tag  = t;
        return e;
    endfunction

    task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                        input logic s, input logic [TW-1:0] t, input exp_t e);
        bit done;
        done     = 1'b0;
        a        = x;
        b        = y;
        cin      = c;
        sub      = s;
        in_tag   = t;
        in_valid = 1'b1;
        for (int k = 0; k < 50 && !done; k++) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back(e);
                n_acc++;
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!done) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout: beat tag %0h not accepted in 50 cycles, expected acceptance", t);
        end
    endtask

    task automatic drain();
        bit empty;
        empty = 1'b0;
        for (int k = 0; k < 100 && !empty; k++) begin
            @(negedge clk);
            if (sb.size() == 0) empty = 1'b1;
            @(posedge clk);
            #1;
        end
        if (!empty) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain_timeout: %0d results outstanding, expected 0", sb.size());
        end
    endtask

    // Compare whatever is presented against the queue head; pop only on handshake,
    // so a stalled output must stay equal to the same expected result.
    always @(negedge clk) begin
        if (mon_en && rst_n && out_valid) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL spurious_out: out_valid=1 tag=%0h sum=%0h, expected no result", out_tag, sum);
            end else begin
                mon_e = sb[0];
                check("sum", sum, mon_e.sum);
                check("cout_ovf_zero", {cout, ovf, zero}, {mon_e.cout, mon_e.ovf, mon_e.zero});
                check("tag", out_tag, mon_e.tag);
                if (out_ready) begin
                    void'(sb.pop_front());
                    n_out++;
                end
            end
        end
    end

    initial begin
        int   lat;
        bit   got;
        int   out_base;
        exp_t e;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        sub       = 1'b0;
        in_tag    = '0;
        out_ready = 1'b1;

        vt[0]  = '{16'h6A98, 16'h2A9A, 1'b0, 1'b0, 16'h9532, 1'b0, 1'b1, 1'b0};
        vt[1]  = '{16'hD53C, 16'hD535, 1'b0, 1'b1, 16'h0007, 1'b1, 1'b0, 1'b0};
        vt[2]  = '{16'hD535, 16'hD53C, 1'b0, 1'b1, 16'hFFF9, 1'b0, 1'b0, 1'b0};
        vt[3]  = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
        vt[4]  = '{16'h7FFF, 16'h0000, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
        vt[5]  = '{16'h1234, 16'h1234, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};
        vt[6]  = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0};
        vt[7]  = '{16'h0000, 16'h0001, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0};
        vt[8]  = '{16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1};
        vt[9]  = '{16'h5555, 16'hAAAA, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
        vt[10] = '{16'h00FF, 16'h0F00, 1'b1, 1'b1, 16'hF1FF, 1'b0, 1'b0, 1'b0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_sum", sum, '0);
        check("rst_flags", {cout, ovf, zero}, 3'b000);
        check("rst_tag", out_tag, '0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("in_ready_after_reset", in_ready, 1'b1);
        mon_en = 1'b1;
        @(posedge clk);
        #1;

        // Single beat into an idle pipe: measure accept-to-valid latency.
        e = '{vt[0].e_sum, vt[0].e_cout, vt[0].e_ovf, vt[0].e_zero, 4'h0};
        send(vt[0].a, vt[0].b, vt[0].cin, vt[0].sub, 4'h0, e);
        lat = 1;
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (out_valid) got = 1'b1;
            else begin
                lat++;
                @(posedge clk);
                #1;
            end
        end
        check("latency", got ? lat : -1, PS);
        drain();

        // Directed table, back to back.
        for (int i = 0; i < 11; i++) begin
            e = '{vt[i].e_sum, vt[i].e_cout, vt[i].e_ovf, vt[i].e_zero, TW'(i)};
            send(vt[i].a, vt[i].b, vt[i].cin, vt[i].sub, TW'(i), e);
        end
        drain();

        // Eight tagged beats with a 3-cycle consumer stall in the middle.
        out_base = n_out;
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    logic [W-1:0] x;
                    logic [W-1:0] y;
                    x = W'($urandom);
                    y = W'($urandom);
                    send(x, y, i[0], i[1], TW'(i), model(x, y, i[0], i[1], TW'(i)));
                end
            end
            begin
                repeat (4) @(posedge clk);
                #1 out_ready = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    check("in_ready_stall", in_ready, 1'b0);
                    check("out_valid_stall", out_valid, 1'b1);
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        drain();
        check("stream_count", n_out - out_base, 8);

        // Two beats in flight, then a one-cycle reset: nothing may emerge afterwards.
        mon_en    = 1'b0;
        out_ready = 1'b0;
        a         = 16'hFFFF;
        b         = 16'hFFFF;
        cin       = 1'b0;
        sub       = 1'b0;
        in_tag    = 4'hA;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        a      = 16'h8001;
        b      = 16'h8001;
        in_tag = 4'hB;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst_n    = 1'b0;
        @(negedge clk);
        check("pre_reset_out_valid", out_valid, 1'b1);
        @(negedge clk);
        check("post_reset_out_valid", out_valid, 1'b0);
        check("post_reset_sum", sum, '0);
        check("post_reset_flags", {cout, ovf, zero}, 3'b000);
        check("post_reset_tag", out_tag, '0);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        out_base  = n_out;
        mon_en    = 1'b1;
        @(negedge clk);
        check("in_ready_after_rst2", in_ready, 1'b1);
        repeat (8) @(posedge clk);
        #1;
        check("no_stale_result", n_out - out_base, 0);

        // Random stream with input bubbles and random consumer backpressure.
        rnd_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 400; i++) begin
                    logic [W-1:0] x;
                    logic [W-1:0] y;
                    logic         c;
                    logic         s;
                    x = W'($urandom);
                    y = W'($urandom);
                    if ($urandom_range(0, 7) == 0) x = '1;
                    if ($urandom_range(0, 7) == 0) y = x;
                    c = 1'($urandom);
                    s = 1'($urandom);
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                    send(x, y, c, s, TW'(i), model(x, y, c, s, TW'(i)));
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1 out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        drain();
        check("total_results", n_out, n_acc);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
